// File: rtl/packet_arbiter_pkg.sv
// Shared encodings and helpers for the packet arbiter slice.
package packet_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/packet_arbiter_id_fifo.sv
// Show-ahead queue of granted port IDs; head steers egress packets home.
module packet_arbiter_id_fifo
  import packet_arbiter_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH) + 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [W-1:0]     i_din,
  input  logic             i_pop,
  output logic [W-1:0]     o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd];
  // A pop frees the slot the same cycle, so push+pop is legal even when full.
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clock)
    if (w_do_push) r_mem[r_wr] <= i_din;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared datapath,
// with an in-order ID queue routing egress packets back to their source port.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_SIZE     = 8,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] in_data,
  input  logic [NUM_PORTS-1:0]           in_valid,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic [NUM_PORTS-1:0]           in_last,
  output logic [DATA_SIZE-1:0]           proc_in_data,
  output logic                           proc_in_valid,
  input  logic                           proc_in_ready,
  output logic                           proc_in_last,
  input  logic [DATA_SIZE-1:0]           proc_out_data,
  input  logic                           proc_out_valid,
  output logic                           proc_out_ready,
  input  logic                           proc_out_last,
  output logic [DATA_SIZE-1:0]           out_data,
  output logic [NUM_PORTS-1:0]           out_valid,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           error
);
  localparam int ID_W  = (clog2(NUM_PORTS) > 1) ? clog2(NUM_PORTS) : 1;
  localparam int CNT_W = clog2(ID_FIFO_DEPTH) + 1;

  arb_state_e       r_state;
  logic [ID_W-1:0]  r_rr_ptr, r_grant;
  logic             r_error;

  logic [ID_W-1:0]  w_sel, w_rr_next, w_head;
  logic             w_push, w_pop, w_full, w_empty;
  logic [CNT_W-1:0] w_count;

  // Scan from the far end so the last hit is the first valid port at/after rr_ptr.
  always_comb begin
    w_sel = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (in_valid[(int'(r_rr_ptr) + k) % NUM_PORTS])
        w_sel = ID_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
    end
  end

  assign w_rr_next = (int'(r_grant) + 1 >= NUM_PORTS) ? '0 : r_grant + ID_W'(1);
  assign w_push    = (r_state == ARB_IDLE) && (|in_valid) && !w_full;
  assign w_pop     = !w_empty && proc_out_valid && proc_out_ready && proc_out_last;

  always_comb begin
    proc_in_data  = '0;
    proc_in_valid = 1'b0;
    proc_in_last  = 1'b0;
    in_ready      = '0;
    if (r_state == ARB_GRANT) begin
      proc_in_data      = in_data[int'(r_grant)*DATA_SIZE +: DATA_SIZE];
      proc_in_valid     = in_valid[r_grant];
      proc_in_last      = in_last[r_grant];
      in_ready[r_grant] = proc_in_ready;
    end
  end

  always_comb begin
    out_valid      = '0;
    proc_out_ready = 1'b0;
    out_data       = '0;
    out_last       = 1'b0;
    if (!w_empty) begin
      out_valid[w_head] = proc_out_valid;
      proc_out_ready    = out_ready[w_head];
      out_data          = proc_out_data;
      out_last          = proc_out_last;
    end
  end

  assign busy  = (r_state == ARB_GRANT) || (w_count != '0);
  assign error = r_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_error  <= 1'b0;
    end else begin
      if (proc_out_valid && w_empty) r_error <= 1'b1;
      case (r_state)
        ARB_IDLE:
          if (w_push) begin
            r_grant <= w_sel;
            r_state <= ARB_GRANT;
          end
        ARB_GRANT:
          if (proc_in_valid && proc_in_ready && proc_in_last) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= ARB_IDLE;
          end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  packet_arbiter_id_fifo #(
    .W     (ID_W),
    .DEPTH (ID_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_id_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_din   (w_sel),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter: grant order, bubbles, queue backpressure, errors, reset.
module tb_packet_arbiter;
  logic        clock, reset;
  logic [15:0] in_data;
  logic [1:0]  in_valid, in_ready, in_last;
  logic [7:0]  proc_in_data, proc_out_data, out_data;
  logic        proc_in_valid, proc_in_ready, proc_in_last;
  logic        proc_out_valid, proc_out_ready, proc_out_last;
  logic [1:0]  out_valid, out_ready;
  logic        out_last, busy, error;

  int n_checks = 0;
  int n_errors = 0;

  packet_arbiter #(.NUM_PORTS(2), .DATA_SIZE(8), .ID_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .proc_in_data(proc_in_data), .proc_in_valid(proc_in_valid),
    .proc_in_ready(proc_in_ready), .proc_in_last(proc_in_last),
    .proc_out_data(proc_out_data), .proc_out_valid(proc_out_valid),
    .proc_out_ready(proc_out_ready), .proc_out_last(proc_out_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_data = '0; in_valid = '0; in_last = '0;
    proc_in_ready = 1'b0;
    proc_out_data = '0; proc_out_valid = 1'b0; proc_out_last = 1'b0;
    out_ready = '0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  logic [7:0]  exp_in [8] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h10, 8'h11, 8'h90, 8'h91};
  logic [1:0]  exp_ov [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
  logic [2:0]  pk [2];
  logic [3:0]  bt [2];
  logic [3:0]  b4;
  logic        rdy;
  int          nb;

  initial begin
    reset = 1'b1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_proc_in_valid", 32'(proc_in_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_proc_out_ready", 32'(proc_out_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_proc_in_data", 32'(proc_in_data), 0);
    chk("rst_out_data", 32'(out_data), 0);

    // T1: 3-beat packet from port 0, then three egress beats back to it
    in_valid = 2'b01; in_data[7:0] = 8'hA1; in_last = 2'b00; proc_in_ready = 1'b1;
    #1;
    chk("t1_bubble_valid", 32'(proc_in_valid), 0);
    chk("t1_bubble_ready", 32'(in_ready), 0);
    step();
    chk("t1_b0_ready", 32'(in_ready), 32'h1);
    chk("t1_b0_data", 32'(proc_in_data), 32'hA1);
    chk("t1_b0_valid", 32'(proc_in_valid), 1);
    step();
    in_data[7:0] = 8'hA2; #1;
    chk("t1_b1_data", 32'(proc_in_data), 32'hA2);
    step();
    in_data[7:0] = 8'hA3; in_last = 2'b01; #1;
    chk("t1_b2_data", 32'(proc_in_data), 32'hA3);
    chk("t1_b2_last", 32'(proc_in_last), 1);
    step();
    in_valid = '0; in_last = '0; #1;
    chk("t1_idle_valid", 32'(proc_in_valid), 0);
    chk("t1_busy_q", 32'(busy), 1);
    out_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      proc_out_valid = 1'b1; proc_out_data = 8'(8'hB1 + i); proc_out_last = (i == 2);
      #1;
      chk("t1_out_valid", 32'(out_valid), 32'h1);
      chk("t1_out_data", 32'(out_data), 32'(8'hB1 + i));
      chk("t1_proc_out_ready", 32'(proc_out_ready), 1);
      step();
    end
    proc_out_valid = 1'b0; proc_out_last = 1'b0; #1;
    chk("t1_busy_done", 32'(busy), 0);
    chk("t1_error", 32'(error), 0);

    // T2: both ports streaming 2-beat packets; grants alternate
    do_reset();
    proc_in_ready = 1'b1;
    pk[0] = 0; pk[1] = 0; bt[0] = 0; bt[1] = 0; nb = 0;
    for (int cyc = 0; cyc < 30 && nb < 8; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        in_data[p*8 +: 8] = {1'(p), pk[p], bt[p]};
        in_last[p] = (bt[p] == 4'd1);
      end
      in_valid = 2'b11;
      #1;
      if (proc_in_valid && proc_in_ready) begin
        chk("t2_data", 32'(proc_in_data), 32'(exp_in[nb]));
        chk("t2_last", 32'(proc_in_last), 32'(nb % 2));
        nb++;
        for (int p = 0; p < 2; p++)
          if (in_ready[p]) begin
            if (bt[p] == 4'd1) begin bt[p] = 0; pk[p] = pk[p] + 3'd1; end
            else bt[p] = bt[p] + 4'd1;
          end
      end
      step();
    end
    chk("t2_beats", 32'(nb), 8);
    in_valid = '0; in_last = '0;
    out_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      proc_out_valid = 1'b1; proc_out_data = 8'(i); proc_out_last = 1'(i % 2);
      #1;
      chk("t2_out_valid", 32'(out_valid), 32'(exp_ov[i]));
      step();
    end
    proc_out_valid = 1'b0; proc_out_last = 1'b0; #1;
    chk("t2_busy_done", 32'(busy), 0);

    // T3: egress stalled, queue fills at 4; 5th grant follows the first pop by one cycle
    do_reset();
    proc_in_ready = 1'b1;
    in_valid = 2'b01; in_last = 2'b01; in_data[7:0] = 8'h55;
    nb = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (proc_in_valid && proc_in_ready) nb++;
      step();
    end
    chk("t3_grants", 32'(nb), 4);
    chk("t3_hold_idle", 32'(proc_in_valid), 0);
    chk("t3_busy", 32'(busy), 1);
    proc_out_valid = 1'b1; proc_out_last = 1'b1; out_ready = 2'b01; #1;
    chk("t3_out_valid", 32'(out_valid), 32'h1);
    step();
    chk("t3_no_grant_on_pop", 32'(proc_in_valid), 0);
    step();
    chk("t3_grant5", 32'(proc_in_valid), 1);
    step();
    in_valid = '0; in_last = '0;
    step(); step();
    proc_out_valid = 1'b0; proc_out_last = 1'b0; #1;
    chk("t3_drained", 32'(busy), 0);
    chk("t3_error", 32'(error), 0);

    // T4: port 1 4-beat packet with proc_in_ready toggling
    do_reset();
    in_valid = 2'b10; in_data[15:8] = 8'hC0; in_last = 2'b00;
    step();
    b4 = 0; rdy = 1'b1; nb = 0;
    for (int cyc = 0; cyc < 14 && nb < 4; cyc++) begin
      in_data[15:8] = 8'hC0 + {4'd0, b4};
      in_last = {(b4 == 4'd3), 1'b0};
      proc_in_ready = rdy;
      #1;
      chk("t4_rdy0", 32'(in_ready[0]), 0);
      chk("t4_rdy1", 32'(in_ready[1]), 32'(rdy));
      if (proc_in_valid && proc_in_ready) begin
        chk("t4_data", 32'(proc_in_data), 32'(8'hC0 + nb));
        nb++;
        b4 = b4 + 4'd1;
      end
      rdy = ~rdy;
      step();
    end
    chk("t4_beats", 32'(nb), 4);
    in_valid = '0; in_last = '0; proc_in_ready = 1'b0;

    // T5: egress with empty queue sets sticky error; reset mid-packet clears everything
    do_reset();
    proc_out_valid = 1'b1; #1;
    chk("t5_no_ready", 32'(proc_out_ready), 0);
    chk("t5_no_out_valid", 32'(out_valid), 0);
    step();
    proc_out_valid = 1'b0; #1;
    chk("t5_error_set", 32'(error), 1);
    step(); step();
    chk("t5_error_sticky", 32'(error), 1);
    proc_in_ready = 1'b1;
    in_valid = 2'b01; in_last = 2'b01; in_data = 16'h0011;
    step(); step();
    in_valid = 2'b10; in_last = 2'b00; in_data = 16'hD000;
    step();
    chk("t5_p1_granted", 32'(in_ready), 32'h2);
    step();
    reset = 1'b1; #1;
    chk("t5_rst_error", 32'(error), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_in_ready", 32'(in_ready), 0);
    chk("t5_rst_proc_in_valid", 32'(proc_in_valid), 0);
    chk("t5_rst_proc_in_data", 32'(proc_in_data), 0);
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    step();
    reset = 1'b0;
    in_valid = 2'b11; in_last = 2'b11;
    step();
    chk("t5_rr_reset", 32'(in_ready), 32'h1);
    in_valid = '0; in_last = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
